// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase scheduler.
//   state_e      : scheduler state codes (0-6, also exported on STATE)
//   DIR_NS/DIR_EW: approach direction encoding (matches EMERG_DIR)
//   DEF_*        : default timing constants shared with the existing controller
//   green_of     : green state belonging to a direction
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GRN   = 3'd0,
    NS_YEL   = 3'd1,
    NS_CLR   = 3'd2,
    EW_GRN   = 3'd3,
    EW_YEL   = 3'd4,
    EW_CLR   = 3'd5,
    PED_WALK = 3'd6
  } state_e;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  localparam int unsigned DEF_MIN_GREEN = 5;
  localparam int unsigned DEF_MAX_GREEN = 20;
  localparam int unsigned DEF_YELLOW_T  = 3;
  localparam int unsigned DEF_ALL_RED_T = 1;
  localparam int unsigned DEF_WALK_T    = 6;
  localparam int unsigned DEF_TW        = 5;

  function automatic state_e green_of(input logic dir);
    return (dir == DIR_NS) ? NS_GRN : EW_GRN;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Signal bundle between the scheduler and its environment.
//   Sensor/request side : NS_CAR, EW_CAR, PED_REQ, EMERG_REQ, EMERG_DIR
//   Lamp/debug side     : NS_/EW_ RED/YELLOW/GREEN, WALK, timer, STATE
//   master : environment (drives sensors, observes lamps)
//   slave  : scheduler   (observes sensors, drives lamps)
interface traffic_phase_scheduler_if
  import traffic_pkg::*;
#(
  parameter int unsigned TW = DEF_TW
) ();

  logic          NS_CAR;
  logic          EW_CAR;
  logic          PED_REQ;
  logic          EMERG_REQ;
  logic          EMERG_DIR;

  logic          NS_RED;
  logic          NS_YELLOW;
  logic          NS_GREEN;
  logic          EW_RED;
  logic          EW_YELLOW;
  logic          EW_GREEN;
  logic          WALK;
  logic [TW-1:0] timer;
  logic [2:0]    STATE;

  modport master (
    output NS_CAR, EW_CAR, PED_REQ, EMERG_REQ, EMERG_DIR,
    input  NS_RED, NS_YELLOW, NS_GREEN, EW_RED, EW_YELLOW, EW_GREEN,
    input  WALK, timer, STATE
  );

  modport slave (
    input  NS_CAR, EW_CAR, PED_REQ, EMERG_REQ, EMERG_DIR,
    output NS_RED, NS_YELLOW, NS_GREEN, EW_RED, EW_YELLOW, EW_GREEN,
    output WALK, timer, STATE
  );

endinterface

// File: rtl/phase_timer.sv
// Cycles-in-state counter: TW-bit up-counter that saturates at all-ones.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset (count -> 0)
//   clr_i   : synchronous clear, takes priority over counting
//   count_o : current count
module phase_timer #(
  parameter int unsigned TW = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  output logic [TW-1:0] count_o
);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (count_q != '1) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Actuated phase scheduler for a 4-way intersection: demand-driven green with
// min/max limits, yellow and all-red clearance, pedestrian walk and emergency
// preempt.
//   CLK     : system clock, rising edge
//   RESET_N : asynchronous active-low reset (state NS_CLR, calls cleared)
//   bus     : sensors/requests in, lamps/WALK/timer/STATE out (slave modport)
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN = DEF_MIN_GREEN,
  parameter int unsigned MAX_GREEN = DEF_MAX_GREEN,
  parameter int unsigned YELLOW_T  = DEF_YELLOW_T,
  parameter int unsigned ALL_RED_T = DEF_ALL_RED_T,
  parameter int unsigned WALK_T    = DEF_WALK_T,
  parameter int unsigned TW        = DEF_TW
) (
  input logic                      CLK,
  input logic                      RESET_N,
  traffic_phase_scheduler_if.slave bus
);

  localparam logic [TW-1:0] MIN_LIM = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_LIM = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_LIM = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] CLR_LIM = TW'(ALL_RED_T - 1);
  localparam logic [TW-1:0] WLK_LIM = TW'(WALK_T - 1);

  state_e        state_q, state_d;
  logic          ns_call_q, ns_call_d;
  logic          ew_call_q, ew_call_d;
  logic          ped_q, ped_d;
  logic          last_dir_q, last_dir_d;
  logic [TW-1:0] timer;
  logic          state_chg;
  logic          emerg_ns;
  logic          emerg_ew;

  // EMERG_DIR only matters while a preempt is active
  assign emerg_ns  = bus.EMERG_REQ && (bus.EMERG_DIR == DIR_NS);
  assign emerg_ew  = bus.EMERG_REQ && (bus.EMERG_DIR == DIR_EW);
  assign state_chg = (state_d != state_q);

  phase_timer #(
    .TW(TW)
  ) u_timer (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .clr_i   (state_chg),
    .count_o (timer)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NS_GRN: begin
        if (emerg_ns) begin
          state_d = NS_GRN;
        end else if (emerg_ew) begin
          state_d = NS_YEL;
        end else if ((ew_call_q || ped_q) && (timer >= MIN_LIM) &&
                     (!bus.NS_CAR || (timer >= MAX_LIM))) begin
          state_d = NS_YEL;
        end
      end
      EW_GRN: begin
        if (emerg_ew) begin
          state_d = EW_GRN;
        end else if (emerg_ns) begin
          state_d = EW_YEL;
        end else if ((ns_call_q || ped_q) && (timer >= MIN_LIM) &&
                     (!bus.EW_CAR || (timer >= MAX_LIM))) begin
          state_d = EW_YEL;
        end
      end
      NS_YEL: if (timer == YEL_LIM) state_d = NS_CLR;
      EW_YEL: if (timer == YEL_LIM) state_d = EW_CLR;
      NS_CLR, EW_CLR: begin
        if (timer == CLR_LIM) begin
          if (bus.EMERG_REQ) begin
            state_d = green_of(bus.EMERG_DIR);
          end else if (ped_q) begin
            state_d = PED_WALK;
          end else begin
            state_d = (state_q == NS_CLR) ? EW_GRN : NS_GRN;
          end
        end
      end
      PED_WALK: begin
        if (timer == WLK_LIM) begin
          state_d = bus.EMERG_REQ ? green_of(bus.EMERG_DIR) : green_of(~last_dir_q);
        end
      end
      default: state_d = NS_CLR;
    endcase
  end

  // A new request in the same cycle as the clearing entry keeps the call set.
  always_comb begin
    ns_call_d  = (bus.NS_CAR && (state_q != NS_GRN)) ||
                 (ns_call_q && !(state_chg && (state_d == NS_GRN)));
    ew_call_d  = (bus.EW_CAR && (state_q != EW_GRN)) ||
                 (ew_call_q && !(state_chg && (state_d == EW_GRN)));
    ped_d      = bus.PED_REQ || (ped_q && !(state_chg && (state_d == PED_WALK)));
    last_dir_d = last_dir_q;
    if (state_chg && (state_d == PED_WALK)) begin
      last_dir_d = (state_q == EW_CLR) ? DIR_EW : DIR_NS;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= NS_CLR;
      ns_call_q  <= 1'b0;
      ew_call_q  <= 1'b0;
      ped_q      <= 1'b0;
      last_dir_q <= DIR_NS;
    end else begin
      state_q    <= state_d;
      ns_call_q  <= ns_call_d;
      ew_call_q  <= ew_call_d;
      ped_q      <= ped_d;
      last_dir_q <= last_dir_d;
    end
  end

  always_comb begin
    bus.NS_RED    = 1'b1;
    bus.NS_YELLOW = 1'b0;
    bus.NS_GREEN  = 1'b0;
    bus.EW_RED    = 1'b1;
    bus.EW_YELLOW = 1'b0;
    bus.EW_GREEN  = 1'b0;
    bus.WALK      = 1'b0;
    unique case (state_q)
      NS_GRN:   begin bus.NS_RED = 1'b0; bus.NS_GREEN  = 1'b1; end
      NS_YEL:   begin bus.NS_RED = 1'b0; bus.NS_YELLOW = 1'b1; end
      EW_GRN:   begin bus.EW_RED = 1'b0; bus.EW_GREEN  = 1'b1; end
      EW_YEL:   begin bus.EW_RED = 1'b0; bus.EW_YELLOW = 1'b1; end
      PED_WALK: bus.WALK = 1'b1;
      default:  ;
    endcase
  end

  assign bus.timer = timer;
  assign bus.STATE = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
module tb_traffic_phase_scheduler;

  localparam int MIN_G = 5;
  localparam int MAX_G = 20;
  localparam int YEL   = 3;
  localparam int ARED  = 1;
  localparam int WLK   = 6;
  localparam int TWID  = 5;
  localparam int TSAT  = 31;

  logic clk;
  logic rst_n;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  traffic_phase_scheduler_if #(.TW(TWID)) bus ();

  traffic_phase_scheduler #(
    .MIN_GREEN (MIN_G),
    .MAX_GREEN (MAX_G),
    .YELLOW_T  (YEL),
    .ALL_RED_T (ARED),
    .WALK_T    (WLK),
    .TW        (TWID)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: phase number (0 NS green, 1 NS yellow, 2 NS clear,
  // 3 EW green, 4 EW yellow, 5 EW clear, 6 walk), time in phase, pending calls.
  int m_st, m_t;
  bit m_nsc, m_ewc, m_ped;
  bit m_last_ew;   // green served before the walk was EW

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [6:0] lamps_for(input int st);
    logic [6:0] l;
    l[6] = !(st == 0 || st == 1);
    l[5] = (st == 1);
    l[4] = (st == 0);
    l[3] = !(st == 3 || st == 4);
    l[2] = (st == 4);
    l[1] = (st == 3);
    l[0] = (st == 6);
    return l;
  endfunction

  function automatic logic [6:0] dut_lamps();
    return {bus.NS_RED, bus.NS_YELLOW, bus.NS_GREEN,
            bus.EW_RED, bus.EW_YELLOW, bus.EW_GREEN, bus.WALK};
  endfunction

  task automatic model_reset();
    m_st = 2; m_t = 0; m_nsc = 0; m_ewc = 0; m_ped = 0; m_last_ew = 0;
  endtask

  task automatic model_step();
    int  nx;
    bit  er, to_ew, ns_car, ew_car;
    er     = bus.EMERG_REQ;
    to_ew  = bus.EMERG_DIR;
    ns_car = bus.NS_CAR;
    ew_car = bus.EW_CAR;
    nx = m_st;
    case (m_st)
      0: if (er) nx = to_ew ? 1 : 0;
         else if ((m_ewc || m_ped) && m_t >= MIN_G - 1 && (!ns_car || m_t >= MAX_G - 1)) nx = 1;
      3: if (er) nx = to_ew ? 3 : 4;
         else if ((m_nsc || m_ped) && m_t >= MIN_G - 1 && (!ew_car || m_t >= MAX_G - 1)) nx = 4;
      1, 4: if (m_t == YEL - 1) nx = m_st + 1;
      2, 5: if (m_t == ARED - 1) begin
              if (er) nx = to_ew ? 3 : 0;
              else if (m_ped) nx = 6;
              else nx = (m_st == 2) ? 3 : 0;
            end
      6: if (m_t == WLK - 1) nx = er ? (to_ew ? 3 : 0) : (m_last_ew ? 0 : 3);
      default: nx = 2;
    endcase
    if (nx == 6 && m_st != 6) m_last_ew = (m_st == 5);
    m_nsc = (ns_car && m_st != 0) || (m_nsc && !(nx == 0 && m_st != 0));
    m_ewc = (ew_car && m_st != 3) || (m_ewc && !(nx == 3 && m_st != 3));
    m_ped = bus.PED_REQ || (m_ped && !(nx == 6 && m_st != 6));
    m_t   = (nx != m_st) ? 0 : ((m_t < TSAT) ? m_t + 1 : TSAT);
    m_st  = nx;
  endtask

  task automatic compare_all();
    chk("state", 32'(bus.STATE), 32'(m_st));
    chk("timer", 32'(bus.timer), 32'(m_t));
    chk("lamps", 32'(dut_lamps()), 32'(lamps_for(m_st)));
    chk("exclusive_green",
        32'((bus.NS_GREEN && bus.EW_GREEN) || ((bus.NS_GREEN || bus.EW_GREEN) && bus.WALK)), 0);
  endtask

  task automatic randomize_inputs();
    if ($urandom_range(15) == 0) bus.NS_CAR = !bus.NS_CAR;
    if ($urandom_range(15) == 0) bus.EW_CAR = !bus.EW_CAR;
    bus.PED_REQ = ($urandom_range(39) == 0);
    if (bus.EMERG_REQ) begin
      if ($urandom_range(24) == 0) bus.EMERG_REQ = 1'b0;
    end else if ($urandom_range(119) == 0) begin
      bus.EMERG_REQ = 1'b1;
    end
    if ($urandom_range(9) == 0) bus.EMERG_DIR = !bus.EMERG_DIR;
  endtask

  // Inputs are stable from this negedge until the next posedge.
  task automatic tick(input bit rnd);
    if (rnd) randomize_inputs();
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic ticks(input int n, input bit rnd);
    for (int i = 0; i < n; i++) tick(rnd);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.NS_CAR    = 1'b0;
    bus.EW_CAR    = 1'b0;
    bus.PED_REQ   = 1'b0;
    bus.EMERG_REQ = 1'b0;
    bus.EMERG_DIR = 1'b0;
    model_reset();

    @(negedge clk);
    @(negedge clk);
    chk("reset_state", 32'(bus.STATE), 2);
    chk("reset_timer", 32'(bus.timer), 0);
    chk("reset_lamps", 32'(dut_lamps()), 32'(7'b1001000));
    rst_n = 1'b1;

    // Idle: one clearance cycle then EW green rests indefinitely.
    tick(0);
    chk("first_green_ew", 32'(bus.EW_GREEN), 1);
    ticks(119, 0);
    chk("idle_ew_hold", 32'(bus.EW_GREEN), 1);

    // NS call ends EW rest; then NS held against EW demand up to max green.
    bus.NS_CAR = 1'b1;
    ticks(12, 0);
    bus.EW_CAR = 1'b1;
    ticks(60, 0);

    // Pedestrian request with no car demand.
    bus.NS_CAR = 1'b0;
    bus.EW_CAR = 1'b0;
    ticks(5, 0);
    bus.PED_REQ = 1'b1;
    tick(0);
    bus.PED_REQ = 1'b0;
    ticks(40, 0);

    // Emergency toward NS with heavy EW demand, held well past max green.
    bus.NS_CAR    = 1'b1;
    bus.EW_CAR    = 1'b1;
    bus.EMERG_DIR = 1'b0;
    bus.EMERG_REQ = 1'b1;
    ticks(45, 0);
    bus.EMERG_REQ = 1'b0;
    ticks(30, 0);

    ticks(4000, 1);

    // Drive into NS yellow via preempt, then reset between clock edges.
    bus.PED_REQ   = 1'b0;
    bus.EMERG_REQ = 1'b1;
    bus.EMERG_DIR = 1'b0;
    for (int i = 0; i < 60 && m_st != 0; i++) tick(0);
    chk("reach_ns_grn", 32'(bus.STATE), 0);
    bus.EMERG_DIR = 1'b1;
    tick(0);
    chk("reach_ns_yel", 32'(bus.STATE), 1);
    bus.EMERG_REQ = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ns_red", 32'(bus.NS_RED), 1);
    chk("async_rst_ew_red", 32'(bus.EW_RED), 1);
    chk("async_rst_timer", 32'(bus.timer), 0);
    chk("async_rst_state", 32'(bus.STATE), 2);
    model_reset();
    @(negedge clk);
    chk("rst_hold_lamps", 32'(dut_lamps()), 32'(7'b1001000));
    rst_n = 1'b1;
    ticks(300, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
